// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte-serialising memory controller for NCH requesters.
// Reads, writes and flushes of 1/2/4-byte transfers share one byte-wide RAM/IO bus.
// Optional feature macro: MEMARB_IO_STALL_EN (IO writes wait on io_buffer_full).
module mem_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [NCH-1:0]      req_valid,
    input  logic [NCH-1:0]      req_we,
    input  logic [2*NCH-1:0]    req_size,
    input  logic [32*NCH-1:0]   req_addr,
    input  logic [32*NCH-1:0]   req_wdata,
    input  logic [NCH-1:0]      flush,
    output logic [NCH-1:0]      req_grant,
    output logic [NCH-1:0]      resp_valid,
    output logic [31:0]         resp_rdata,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [ADDR_W-1:0]   mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] own_q, own_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    n_q, n_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          iss_q, iss_d;
    logic [1:0]    iss_k_q, iss_k_d;
    logic          resp_pend_q, resp_pend_d;
    logic [CW-1:0] resp_ch_q, resp_ch_d;

    logic          go, do_grant, abort, active, io_stall, issue, gnt_found;
    logic [CW-1:0] gnt_idx;
    logic [NCH-1:0] elig;
    logic [31:0]   cur_addr, cur_wdata;
    logic          cur_we;
    logic [2:0]    cur_n, cur_k;

    function automatic logic [2:0] size_len(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign go       = rdy && !rst;
    assign elig     = req_valid & ~flush;
    assign do_grant = go && (state_q == S_IDLE) && gnt_found;
    assign abort    = go && (state_q == S_READ) && flush[own_q];

    // Round-robin pick: first eligible channel at or after the priority pointer.
    always_comb begin
        int unsigned j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            j = (i + 32'(ptr_q)) % NCH;
            if (!gnt_found && elig[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'(j);
            end
        end
    end

    // Current transfer view: the request being granted, else the captured one.
    always_comb begin
        if (do_grant) begin
            cur_addr  = req_addr[32*gnt_idx +: 32];
            cur_wdata = req_wdata[32*gnt_idx +: 32];
            cur_we    = req_we[gnt_idx];
            cur_n     = size_len(req_size[2*gnt_idx +: 2]);
            cur_k     = 3'd0;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_we    = we_q;
            cur_n     = n_q;
            cur_k     = cnt_q;
        end
    end

`ifdef MEMARB_IO_STALL_EN
    assign io_stall = cur_we && (cur_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
`endif

    assign active = do_grant
                 || (go && (state_q == S_READ) && !abort && (cnt_q < n_q))
                 || (go && (state_q == S_WRITE));
    assign issue  = active && !io_stall;

    assign mem_a    = issue ? ADDR_W'(cur_addr + 32'(cur_k)) : '0;
    assign mem_dout = (issue && cur_we) ? cur_wdata[8*cur_k[1:0] +: 8] : '0;
    assign mem_wr   = issue && cur_we;

    assign req_grant  = do_grant ? (NCH'(1) << gnt_idx) : '0;
    assign resp_valid = (resp_pend_q && go) ? (NCH'(1) << resp_ch_q) : '0;
    assign resp_rdata = (resp_pend_q && go) ? rdata_q : '0;

    // Next-state: byte capture runs even while rdy is low; sequencing only when go.
    always_comb begin
        logic complete;
        complete    = 1'b0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        addr_d      = addr_q;
        we_d        = we_q;
        n_d         = n_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        iss_d       = issue && !cur_we;
        iss_k_d     = cur_k[1:0];
        resp_pend_d = go ? 1'b0 : resp_pend_q;
        resp_ch_d   = resp_ch_q;

        if (iss_q && !abort)
            rdata_d[8*iss_k_q +: 8] = mem_din;

        case (state_q)
            S_IDLE: begin
                if (do_grant) begin
                    ptr_d   = CW'((int'(gnt_idx) + 1) % NCH);
                    own_d   = gnt_idx;
                    addr_d  = cur_addr;
                    we_d    = cur_we;
                    n_d     = cur_n;
                    wdata_d = cur_wdata;
                    rdata_d = '0;
                    if (!issue) begin
                        cnt_d   = 3'd0;
                        state_d = S_WRITE;
                    end else if (cur_we && (cur_n == 3'd1)) begin
                        cnt_d    = 3'd1;
                        state_d  = S_IDLE;
                        complete = 1'b1;
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = cur_we ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                if (go) begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (cnt_q < n_q) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        state_d  = S_IDLE;
                        complete = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (issue) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == n_q) begin
                        state_d  = S_IDLE;
                        complete = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            resp_pend_d = 1'b1;
            resp_ch_d   = do_grant ? gnt_idx : own_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            own_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            n_q         <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            iss_q       <= 1'b0;
            iss_k_q     <= '0;
            resp_pend_q <= 1'b0;
            resp_ch_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            n_q         <= n_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            iss_q       <= iss_d;
            iss_k_q     <= iss_k_d;
            resp_pend_q <= resp_pend_d;
            resp_ch_q   <= resp_ch_d;
        end
    end

endmodule
